// File: rtl/eq_ffe.sv
// eq_ffe: 7-tap (default) feed-forward equalizer with training / decision-directed
// slicer.
//
// The pipeline runs freely in four stages:
//   1. delay line: shifts only when i_en is high
//   2. products: registered every clock
//   3. y: the products are summed, rescaled and saturated, then registered
//   4. decision and error: loaded only when a valid sample arrives
//
// Ports:
//   i_clk, i_rst       clock; asynchronous active-high reset
//   i_en               sample strobe, qualifies i_data and i_train_sym
//   i_data             received sample, S(11,7)
//   i_train_sym        known training symbol (1 = +1.0, 0 = -1.0)
//   i_force_train      one-cycle request to go back to TRAIN
//   i_coefs            packed taps, S(9,7) each, tap k at [COEF_BW*(k+1)-1 : COEF_BW*k]
//   o_data             equalized sample y, S(11,7)
//   o_sym              decision (1 = +1.0, 0 = -1.0)
//   o_error            d - y saturated to S(8,7)
//   o_valid            one-cycle strobe qualifying o_data / o_sym / o_error
//   o_mode             0 = TRAIN, 1 = DD
module eq_ffe #(
  parameter int DATA_BW   = 11,
  parameter int COEF_BW   = 9,
  parameter int N_COEF    = 7,
  parameter int TRAIN_LEN = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [DATA_BW-1:0]         i_data,
  input  logic                       i_train_sym,
  input  logic                       i_force_train,
  input  logic [COEF_BW*N_COEF-1:0]  i_coefs,
  output logic [DATA_BW-1:0]         o_data,
  output logic                       o_sym,
  output logic [7:0]                 o_error,
  output logic                       o_valid,
  output logic                       o_mode
);

  localparam int FRAC_SH = 7;                          // coefficient fraction bits
  localparam int PROD_BW = DATA_BW + COEF_BW;
  localparam int SUM_BW  = PROD_BW + $clog2(N_COEF);
  localparam int Y_TOP   = FRAC_SH + DATA_BW - 1;      // MSB of y inside the sum
  localparam int ERR_BW  = DATA_BW + 1;

  localparam logic [DATA_BW-1:0] Y_MAX = {1'b0, {(DATA_BW-1){1'b1}}};
  localparam logic [DATA_BW-1:0] Y_MIN = {1'b1, {(DATA_BW-1){1'b0}}};
  localparam logic signed [ERR_BW-1:0] D_POS = ERR_BW'(128);
  localparam logic signed [ERR_BW-1:0] D_NEG = -D_POS;
  localparam logic signed [ERR_BW-1:0] E_MAX = ERR_BW'(127);

  typedef enum logic {
    MODE_TRAIN = 1'b0,
    MODE_DD    = 1'b1
  } mode_e;

  logic signed [DATA_BW-1:0] dl_q   [N_COEF];
  logic signed [DATA_BW-1:0] dl_d   [N_COEF];
  logic signed [PROD_BW-1:0] prod_q [N_COEF];
  logic signed [PROD_BW-1:0] prod_d [N_COEF];
  logic signed [DATA_BW-1:0] y_q, y_d;
  logic [3:0]                vld_q, vld_d;
  logic [2:0]                sym_q, sym_d;
  logic [DATA_BW-1:0]        data_q, data_d;
  logic                      dec_q, dec_d;
  logic [7:0]                err_q, err_d;
  mode_e                     mode_q, mode_d;
  logic [15:0]               cnt_q, cnt_d;

  logic signed [SUM_BW-1:0]    sum;
  logic [SUM_BW-Y_TOP-1:0]     ovf_bits;
  logic                        dec_pos;
  logic signed [ERR_BW-1:0]    d_val;
  logic signed [ERR_BW-1:0]    diff;

  always_comb begin
    // Stage 1: delay line and the training symbol that travels with the sample
    for (int unsigned k = 0; k < N_COEF; k++) dl_d[k] = dl_q[k];
    if (i_en) begin
      dl_d[0] = i_data;
      for (int unsigned k = 1; k < N_COEF; k++) dl_d[k] = dl_q[k-1];
    end
    vld_d = {vld_q[2:0], i_en};
    sym_d = {sym_q[1:0], (i_en ? i_train_sym : sym_q[0])};

    // Stage 2: full-precision products, coefficients taken straight from the port
    for (int unsigned k = 0; k < N_COEF; k++) begin
      prod_d[k] = PROD_BW'(dl_q[k]) *
                  PROD_BW'($signed(i_coefs[COEF_BW*k +: COEF_BW]));
    end

    // Stage 3: exact sum, then keep S(11,7); clamp when the bits above y's MSB
    // are not a pure sign extension
    sum = '0;
    for (int unsigned k = 0; k < N_COEF; k++) sum = sum + SUM_BW'(prod_q[k]);
    ovf_bits = sum[SUM_BW-1:Y_TOP];
    if ((ovf_bits == '0) || (ovf_bits == '1)) y_d = sum[Y_TOP:FRAC_SH];
    else                                      y_d = sum[SUM_BW-1] ? Y_MIN : Y_MAX;

    // Stage 4: slicer and error, using the mode present when these registers load
    dec_pos = (mode_q == MODE_TRAIN) ? sym_q[2] : ~y_q[DATA_BW-1];
    d_val   = dec_pos ? D_POS : D_NEG;
    diff    = d_val - $signed({y_q[DATA_BW-1], y_q});
    data_d  = data_q;
    dec_d   = dec_q;
    err_d   = err_q;
    if (vld_q[2]) begin
      data_d = y_q;
      dec_d  = dec_pos;
      if (diff > E_MAX)      err_d = 8'h7f;
      else if (diff < D_NEG) err_d = 8'h80;
      else                   err_d = diff[7:0];
    end

    // Mode: a force request wins over the terminal count on the same edge
    mode_d = mode_q;
    cnt_d  = cnt_q;
    if (i_force_train) begin
      mode_d = MODE_TRAIN;
      cnt_d  = '0;
    end else if ((mode_q == MODE_TRAIN) && vld_q[2]) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_q + 16'd1 == 16'(TRAIN_LEN)) mode_d = MODE_DD;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < N_COEF; k++) begin
        dl_q[k]   <= '0;
        prod_q[k] <= '0;
      end
      y_q    <= '0;
      vld_q  <= '0;
      sym_q  <= '0;
      data_q <= '0;
      dec_q  <= 1'b0;
      err_q  <= '0;
      mode_q <= MODE_TRAIN;
      cnt_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < N_COEF; k++) begin
        dl_q[k]   <= dl_d[k];
        prod_q[k] <= prod_d[k];
      end
      y_q    <= y_d;
      vld_q  <= vld_d;
      sym_q  <= sym_d;
      data_q <= data_d;
      dec_q  <= dec_d;
      err_q  <= err_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_data  = data_q;
  assign o_sym   = dec_q;
  assign o_error = err_q;
  assign o_valid = vld_q[3];
  assign o_mode  = mode_q;

endmodule

// File: tb/tb_eq_ffe.sv
// Bench for eq_ffe with TRAIN_LEN=4. A behavioural model computes each output
// with integer arithmetic (dot product, floor divide by 128, clamp) and keeps a
// queue of pending results, each tagged with the edge on which it must appear.
module tb_eq_ffe;
  localparam int DW = 11;
  localparam int CW = 9;
  localparam int NC = 7;
  localparam int TL = 4;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_en = 1'b0;
  logic [DW-1:0]     i_data = '0;
  logic              i_train_sym = 1'b0;
  logic              i_force_train = 1'b0;
  logic [CW*NC-1:0]  i_coefs = '0;
  logic [DW-1:0]     o_data;
  logic              o_sym;
  logic [7:0]        o_error;
  logic              o_valid;
  logic              o_mode;

  eq_ffe #(.DATA_BW(DW), .COEF_BW(CW), .N_COEF(NC), .TRAIN_LEN(TL)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_data(i_data),
    .i_train_sym(i_train_sym), .i_force_train(i_force_train), .i_coefs(i_coefs),
    .o_data(o_data), .o_sym(o_sym), .o_error(o_error), .o_valid(o_valid),
    .o_mode(o_mode)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int due; int y; bit sym; } pend_t;

  int     n_chk = 0;
  int     n_pass = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     coef [NC];
  int     hist [NC];
  pend_t  pq [$];
  bit     dd = 1'b0;
  int     tcnt = 0;
  string  ph = "init";
  logic [DW-1:0] exp_data = '0;
  logic          exp_sym = 1'b0;
  logic [7:0]    exp_err = '0;
  logic          exp_valid = 1'b0;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int model_y();
    int acc = 0;
    for (int k = 0; k < NC; k++) acc += hist[k] * coef[k];
    return clamp(acc >>> 7, -1024, 1023);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0d expected %0d (edge %0d)", ph, tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    chk("valid", 32'(o_valid), 32'(exp_valid));
    chk("mode",  32'(o_mode),  32'(dd));
    chk("data",  32'(o_data),  32'(exp_data));
    chk("sym",   32'(o_sym),   32'(exp_sym));
    chk("error", 32'(o_error), 32'(exp_err));
  endtask

  task automatic load_coefs();
    for (int k = 0; k < NC; k++) i_coefs[CW*k +: CW] = CW'(coef[k]);
  endtask

  // One clock: drive inputs, advance the model across the edge, check 1 unit later.
  task automatic tick(input bit en, input int data, input bit sym, input bit frc);
    pend_t p;
    bit    got;
    bit    dec;
    int    e;
    i_en = en; i_data = DW'(data); i_train_sym = sym; i_force_train = frc;
    @(posedge i_clk);
    cyc++;
    if (en) begin
      for (int k = NC - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = data;
      p.due = cyc + 3; p.y = model_y(); p.sym = sym;
      pq.push_back(p);
    end
    got = (pq.size() > 0) && (pq[0].due == cyc);
    exp_valid = got;
    if (got) begin
      p = pq.pop_front();
      dec = dd ? (p.y >= 0) : p.sym;
      e = clamp((dec ? 128 : -128) - p.y, -128, 127);
      exp_data = DW'(p.y);
      exp_sym = dec;
      exp_err = 8'(e);
    end
    if (frc) begin
      dd = 1'b0; tcnt = 0;
    end else if (!dd && got) begin
      tcnt++;
      if (tcnt == TL) dd = 1'b1;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0, 1'b0);
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    i_en = 1'b0; i_force_train = 1'b0;
    i_rst = 1'b1;
    #2;
    pq.delete();
    for (int k = 0; k < NC; k++) hist[k] = 0;
    dd = 1'b0; tcnt = 0;
    exp_valid = 1'b0; exp_data = '0; exp_sym = 1'b0; exp_err = '0;
    check_outputs();
    @(posedge i_clk);
    cyc++;
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NC; k++) begin coef[k] = 0; hist[k] = 0; end
    #1;
    ph = "reset";
    pulse_reset();

    ph = "center64";
    for (int k = 0; k < NC; k++) coef[k] = (k == 3) ? 128 : 0;
    load_coefs();
    for (int i = 0; i < 4; i++) tick(1'b1, 64, 1'b1, 1'b0);
    idle(4);

    ph = "dd_neg32";
    for (int i = 0; i < 5; i++) tick(1'b1, -32, 1'b1, 1'b0);
    idle(4);

    ph = "sat_pos";
    for (int k = 0; k < NC; k++) coef[k] = 255;
    load_coefs();
    for (int i = 0; i < 10; i++) tick(1'b1, 1023, 1'b1, 1'b0);
    idle(4);

    ph = "en_gap";
    for (int k = 0; k < NC; k++) coef[k] = (k == 0) ? 64 : ((k == 1) ? -32 : 16);
    load_coefs();
    tick(1'b1, 300, 1'b0, 1'b0);
    tick(1'b0, 999, 1'b1, 1'b0);
    tick(1'b1, -500, 1'b1, 1'b0);
    tick(1'b0, -7, 1'b0, 1'b0);
    tick(1'b1, 200, 1'b0, 1'b0);
    idle(4);

    ph = "force";
    tick(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, int'($urandom_range(0, 2047)) - 1024, 1'($urandom), 1'b0);
    tick(1'b1, 100, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) tick(1'b1, int'($urandom_range(0, 2047)) - 1024, 1'($urandom), 1'b0);
    idle(4);

    ph = "rst_flight";
    for (int i = 0; i < 3; i++) tick(1'b1, 500, 1'b1, 1'b0);
    pulse_reset();
    idle(6);
    tick(1'b1, 77, 1'b1, 1'b0);
    idle(5);

    ph = "random";
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < NC; k++)
        coef[k] = (s % 2 == 0) ? int'($urandom_range(0, 511)) - 256 : int'($urandom_range(0, 127)) - 64;
      load_coefs();
      for (int i = 0; i < 60; i++)
        tick($urandom_range(0, 3) != 0, int'($urandom_range(0, 2047)) - 1024,
             1'($urandom), $urandom_range(0, 39) == 0);
      idle(4);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
